// File: rtl/cr_kme_fifo_pkg.sv
// cr_kme_fifo_pkg
// Shared definitions for the KME parametrised FIFO:
//   OVFL_BIT / UFL_BIT : bit positions inside err_sticky
//   ptr_inc            : wrap-aware pointer increment for any depth,
//                        including depths that are not a power of two
package cr_kme_fifo_pkg;

  localparam int OVFL_BIT = 1;
  localparam int UFL_BIT  = 0;

  // Wraps from depth-1 back to 0 by explicit compare. A plain binary
  // rollover would only be correct when depth is a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    if (ptr == depth - 1) return 0;
    return ptr + 1;
  endfunction

endpackage

// File: rtl/cr_kme_fifo_mem.sv
// cr_kme_fifo_mem
// DATA_SIZE x FIFO_DEPTH register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset; the
// control logic guarantees nothing is read before it has been written.
// Ports:
//   clk   : clock
//   wen   : write enable
//   waddr : write index (0..FIFO_DEPTH-1)
//   wdata : write data
//   raddr : read index (0..FIFO_DEPTH-1)
//   rdata : combinational read data at raddr
module cr_kme_fifo_mem #(
  parameter int DATA_SIZE  = 34,
  parameter int FIFO_DEPTH = 4,
  parameter int PW         = 2
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic [PW-1:0]        waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [PW-1:0]        raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cr_kme_param_fifo.sv
// cr_kme_param_fifo
// Parametrised synchronous FIFO used to stage data between KME pipeline
// stages, with programmable stall threshold, occupancy / high-water-mark
// reporting, sticky error flags and a synchronous flush.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   fifo_in, fifo_in_valid  : write data / write request
//   fifo_in_stall           : upstream must stop issuing writes
//   fifo_in_stall_override  : forces stall low when OVERRIDE_EN=1
//   fifo_out, fifo_out_valid: head data / FIFO not empty
//   fifo_out_ack            : pop head
//   fifo_clear              : synchronous flush (highest priority)
//   used_slots, free_slots  : occupancy and remaining room
//   hwm                     : peak used_slots since reset/clear
//   fifo_overflow           : one-cycle pulse, a write was dropped
//   fifo_underflow          : one-cycle pulse, ack arrived while empty
//   err_sticky              : {overflow_seen, underflow_seen}
//
// Handshake: a word is written on any cycle with fifo_in_valid=1 and room
// (not full, or a pop in the same cycle); the upstream is expected to
// honour fifo_in_stall, which asserts early by STALL_AT slots so that
// words already in flight still fit. A word is consumed on any cycle with
// fifo_out_valid=1 and fifo_out_ack=1; fifo_out is stable until consumed.
module cr_kme_param_fifo
  import cr_kme_fifo_pkg::*;
#(
  parameter int DATA_SIZE   = 34,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_AT    = 0,
  parameter int OVERRIDE_EN = 0,
  parameter int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_stall,
  input  logic                 fifo_in_stall_override,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  input  logic                 fifo_out_ack,
  input  logic                 fifo_clear,
  output logic [CW-1:0]        used_slots,
  output logic [CW-1:0]        free_slots,
  output logic [CW-1:0]        hwm,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  output logic [1:0]           err_sticky
);

  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_C  = CW'(STALL_AT);
  localparam logic          OVR_EN   = (OVERRIDE_EN != 0);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          ren;
  logic          wen;
  logic          mem_wen;
  logic [CW-1:0] used_next;

  assign full           = (used_slots == DEPTH_C);
  assign fifo_out_valid = (used_slots != '0);
  assign free_slots     = DEPTH_C - used_slots;
  assign ren            = fifo_out_valid & fifo_out_ack;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wen            = fifo_in_valid & (~full | ren);
  assign mem_wen        = wen & ~fifo_clear;

  assign fifo_in_stall  = (free_slots <= STALL_C) &
                          ~(OVR_EN & fifo_in_stall_override);

  always_comb begin
    used_next = used_slots;
    if (wen && !ren)      used_next = used_slots + CW'(1);
    else if (ren && !wen) used_next = used_slots - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      used_slots     <= '0;
      hwm            <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
      err_sticky     <= 2'b00;
    end else if (fifo_clear) begin
      wptr           <= '0;
      rptr           <= '0;
      used_slots     <= '0;
      hwm            <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
      err_sticky     <= 2'b00;
    end else begin
      if (wen) wptr <= PW'(ptr_inc(32'(wptr), FIFO_DEPTH));
      if (ren) rptr <= PW'(ptr_inc(32'(rptr), FIFO_DEPTH));
      used_slots <= used_next;
      // used_next never exceeds FIFO_DEPTH, so hwm saturates there.
      if (used_next > hwm) hwm <= used_next;
      fifo_overflow  <= fifo_in_valid & full & ~ren;
      fifo_underflow <= fifo_out_ack & ~fifo_out_valid;
      if (fifo_in_valid && full && !ren) err_sticky[OVFL_BIT] <= 1'b1;
      if (fifo_out_ack && !fifo_out_valid) err_sticky[UFL_BIT] <= 1'b1;
    end
  end

  cr_kme_fifo_mem #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk   (clk),
    .wen   (mem_wen),
    .waddr (wptr),
    .wdata (fifo_in),
    .raddr (rptr),
    .rdata (fifo_out)
  );

endmodule

// File: doc/cr_kme_param_fifo.md
Name: cr_kme_param_fifo

Overview:
Parametrised, self-contained synchronous FIFO for KME datapath staging. It generalises the fixed 34-bit/2-deep KME stall FIFO to any width and depth, and adds:
- a programmable stall threshold with override,
- occupancy and high-water-mark reporting,
- sticky error flags,
- a synchronous flush.

It sits between KME pipeline stages. The upstream stage honours fifo_in_stall; the downstream stage pops with fifo_out_ack.

Parameters:
DATA_SIZE, 34, payload width in bits (>=1)
FIFO_DEPTH, 4, number of entries (>=2; need not be a power of 2)
STALL_AT, 0, assert stall when free_slots <= STALL_AT (0..FIFO_DEPTH-1)
OVERRIDE_EN, 0, 1 enables the fifo_in_stall_override input
CW, $clog2(FIFO_DEPTH+1), derived count width; not to be overridden

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fifo_in  input  DATA_SIZE  write data
fifo_in_valid  input  1  write request
fifo_in_stall  output  1  upstream must stop issuing writes
fifo_in_stall_override  input  1  forces fifo_in_stall low when OVERRIDE_EN=1; ignored otherwise
fifo_out  output  DATA_SIZE  head-of-queue data
fifo_out_valid  output  1  FIFO not empty
fifo_out_ack  input  1  pop head
fifo_clear  input  1  synchronous flush
used_slots  output  CW  current occupancy
free_slots  output  CW  FIFO_DEPTH - used_slots
hwm  output  CW  maximum used_slots since reset/clear
fifo_overflow  output  1  one-cycle pulse: write dropped
fifo_underflow  output  1  one-cycle pulse: ack while empty
err_sticky  output  2  {overflow_seen, underflow_seen}; clears on reset/fifo_clear

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr=rptr=0, used_slots=0, hwm=0, err_sticky=0, overflow/underflow=0.
  - fifo_out_valid=0 and fifo_in_stall=(0 >= ... ) per formula, i.e. (FIFO_DEPTH <= STALL_AT) = 0.
  - Storage array is not reset; fifo_out is don't-care while fifo_out_valid=0.
- Read-enable and write-enable:
  - ren = fifo_out_valid & fifo_out_ack.
  - wen = fifo_in_valid & (!full | ren), where full = (used_slots == FIFO_DEPTH).
- Write: registered into mem[wptr]. The entry is visible on fifo_out the next cycle; write-to-valid latency is 1. There is no same-cycle bypass.
- Read:
  - fifo_out = mem[rptr], combinational from registered state.
  - On ren, rptr advances and the next entry appears on the following cycle.
- Pointers wrap from FIFO_DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- Simultaneous write and read:
  - used_slots is unchanged; both pointers advance.
  - When full, the write is accepted because the read frees a slot.
  - When empty, ren=0, so only the write occurs.
- Overflow: fifo_in_valid & full & !ren.
  - Data is dropped and nothing changes.
  - fifo_overflow pulses the next cycle (registered) and err_sticky[1] sets.
- Underflow: fifo_out_ack & !fifo_out_valid.
  - Pointers are untouched.
  - fifo_underflow pulses the next cycle and err_sticky[0] sets.
- Stall: fifo_in_stall = (free_slots <= STALL_AT) & !(OVERRIDE_EN & fifo_in_stall_override).
  - Combinational from registered count.
  - The STALL_AT slack slots absorb upstream pipeline latency.
- hwm updates to the next-state used_slots whenever that value exceeds it. hwm saturates at FIFO_DEPTH.
- fifo_clear (synchronous) has priority over all other events:
  - next cycle: pointers, count, hwm and err_sticky are 0;
  - same-cycle write/read are discarded;
  - overflow/underflow are not flagged for that cycle.
- Reset mid-operation discards all contents. No output glitches other than the asynchronous drop to reset values.

Decomposition:
- Package cr_kme_fifo_pkg holds:
  - the err_sticky bit index constants OVFL_BIT=1, UFL_BIT=0;
  - a ptr_inc function (wrap-aware increment).
- One natural sub-module: cr_kme_fifo_mem, a DATA_SIZE x FIFO_DEPTH register array with one write port and one async read port.
- Control (pointers, count, flags, hwm) stays in the top level.

Test Plan:
- DEPTH=4, STALL_AT=1: write 3 words (0xA,0xB,0xC) with no ack -> stall goes high after the 3rd write (free=1), used_slots=3, hwm=3; then ack 3 cycles -> fifo_out sequence A,B,C, fifo_out_valid low after the 3rd pop, hwm stays 3.
- DEPTH=3 (non power of 2): 10 push/pop pairs across wrap -> data order preserved, rptr/wptr wrap 2->0, used_slots stays within 0..3.
- Full (4 entries), valid without ack -> fifo_overflow pulses 1 cycle, err_sticky=2'b10, contents unchanged; full with valid+ack same cycle -> no overflow, used_slots stays 4, new word appears last.
- Empty with ack=1 -> fifo_underflow pulse, err_sticky[0]=1, used_slots stays 0; fifo_clear -> err_sticky=0, hwm=0.
- OVERRIDE_EN=1, free_slots=0, override=1 -> fifo_in_stall=0; override with OVERRIDE_EN=0 -> stall stays 1.
- rst_n low while holding 2 entries -> immediately fifo_out_valid=0, used_slots=0; after release, first write reads back correctly.
